// File: rtl/sr_btn_ctrl_pkg.sv
// Shared definitions for the button-to-SR command stage: arbiter state
// encodings and the default debounce length.
package sr_btn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SET      = 2'd1,
        ST_RST      = 2'd2,
        ST_CONFLICT = 2'd3
    } arb_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sr_btn_ctrl_debounce.sv
// One raw button: two-flop synchronizer, consecutive-cycle debounce counter
// and a rising-edge detector producing a one-cycle request.
module btn_debounce
    import sr_btn_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic deb_out,
    output logic rise_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        // Any cycle where the synchronized level agrees with deb restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            cnt_q     <= cnt_d;
        end
    end

    assign deb_out    = deb_q;
    assign rise_pulse = deb_q & ~deb_dly_q;

endmodule

// File: rtl/sr_btn_ctrl.sv
// Turns two bouncy buttons into clean, mutually exclusive one-cycle S/R
// pulses for sr_ff, plus a commanded-state shadow and a conflict flag.
module sr_btn_ctrl
    import sr_btn_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_rst,
    output logic S,
    output logic R,
    output logic q_cmd,
    output logic conflict
);

    logic       set_req, rst_req;
    logic [1:0] deb_levels_unused;

    arb_state_e state_q, state_d;
    logic       q_cmd_q, q_cmd_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set_deb (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_set),
        .deb_out    (deb_levels_unused[0]),
        .rise_pulse (set_req)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_rst_deb (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_rst),
        .deb_out    (deb_levels_unused[1]),
        .rise_pulse (rst_req)
    );

    // Every state lasts one cycle; the next state depends only on this cycle's requests.
    always_comb begin
        state_d = ST_IDLE;
        q_cmd_d = q_cmd_q;
        case ({set_req, rst_req})
            2'b10:   state_d = ST_SET;
            2'b01:   state_d = ST_RST;
            2'b11:   state_d = ST_CONFLICT;
            default: state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_SET:      q_cmd_d = 1'b1;
            ST_RST:      q_cmd_d = 1'b0;
            ST_CONFLICT: q_cmd_d = 1'b0;
            default:     q_cmd_d = q_cmd_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_cmd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_cmd_q <= q_cmd_d;
        end
    end

    // A simultaneous press resolves to reset, so S and R can never both be high.
    assign S        = (state_q == ST_SET);
    assign R        = (state_q == ST_RST) || (state_q == ST_CONFLICT);
    assign conflict = (state_q == ST_CONFLICT);
    assign q_cmd    = q_cmd_q;

endmodule

// File: tb/tb_sr_btn_ctrl.sv
// Directed bench for sr_btn_ctrl with DEBOUNCE_CYCLES=4: a press sampled at
// posedge 1 of a window yields its pulse right after posedge 7 of that window.
module tb_sr_btn_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic S, R, q_cmd, conflict;

  int tests_run = 0;
  int tests_failed = 0;

  sr_btn_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_set  (btn_set),
    .btn_rst  (btn_rst),
    .S        (S),
    .R        (R),
    .q_cmd    (q_cmd),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  // S and R must never be high together, including right after reset.
  always @(negedge clk) begin
    assert (!(S && R)) else begin
      tests_failed++;
      $display("FAIL s_r_exclusive: got S=%b R=%b, required not both 1", S, R);
    end
  end

  // Drive buttons away from the edge, then sample outputs 1 time unit after it.
  task automatic tick(input logic bs, input logic br);
    @(negedge clk);
    btn_set = bs;
    btn_rst = br;
    @(posedge clk);
    #1;
  endtask

  task automatic test_release(input int n);
    logic [2:0] got;
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, 1'b0);
      got = {S, R, conflict};
      tests_run++;
      if (got !== 3'b000) begin
        tests_failed++;
        $display("FAIL release_quiet cycle %0d: got {S,R,conflict}=%b required 000", i, got);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1;
    btn_set = 1'b0;
    btn_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {S, R, conflict, q_cmd};
    tests_run++;
    if (got !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_hold: got {S,R,conflict,q_cmd}=%b required 0000", got);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 1'b0);
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: got {S,R,conflict,q_cmd}=%b required 0000", i, got);
      end
    end
  endtask

  task automatic test_single_press();
    logic [3:0] got, exp;
    for (int i = 1; i <= 30; i++) begin
      tick(1'b1, 1'b0);
      exp = {(i == 7), 1'b0, 1'b0, (i >= 7)};
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL single_press cycle %0d: got {S,R,conflict,q_cmd}=%b required %b", i, got, exp);
      end
    end
  endtask

  // 1,0,1,0 then held: the final 0->1 is sampled at posedge 5, pulse after posedge 11.
  task automatic test_bounce();
    logic [3:0] got, exp;
    logic bs;
    for (int i = 1; i <= 24; i++) begin
      bs = (i >= 5) ? 1'b1 : ((i % 2) == 1);
      tick(bs, 1'b0);
      exp = {(i == 11), 1'b0, 1'b0, 1'b1};
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL bounce cycle %0d: got {S,R,conflict,q_cmd}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_conflict();
    logic [3:0] got, exp;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 1'b1);
      exp = {1'b0, (i == 7), (i == 7), (i < 7)};
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL conflict cycle %0d: got {S,R,conflict,q_cmd}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, (i >= 2));
      exp = {(i == 7), (i == 8), 1'b0, (i == 7)};
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back cycle %0d: got {S,R,conflict,q_cmd}=%b required %b", i, got, exp);
      end
    end
  endtask

  // Set once, then press reset twice with a 10-cycle release in between.
  task automatic test_repress();
    logic [3:0] got, exp;
    logic bs, br;
    for (int i = 1; i <= 50; i++) begin
      bs = (i <= 10);
      br = (i >= 21 && i <= 30) || (i >= 41);
      tick(bs, br);
      exp = {(i == 7), (i == 27 || i == 47), 1'b0, (i >= 7 && i < 27)};
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL repress cycle %0d: got {S,R,conflict,q_cmd}=%b required %b", i, got, exp);
      end
    end
  endtask

  // Shared tail for the reset scenarios: button still held when reset releases.
  task automatic held_after_reset(input logic q_before);
    logic [3:0] got, exp;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      exp = {(i == 7), 1'b0, 1'b0, (i >= 7) ? 1'b1 : q_before};
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL held_after_reset cycle %0d: got {S,R,conflict,q_cmd}=%b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0] got;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 1'b0);
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== 4'b0000) begin
        tests_failed++;
        $display("FAIL debounce_pre_reset cycle %0d: got {S,R,conflict,q_cmd}=%b required 0000", i, got);
      end
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== 4'b0000) begin
        tests_failed++;
        $display("FAIL debounce_in_reset step %0d: got {S,R,conflict,q_cmd}=%b required 0000", i, got);
      end
      @(posedge clk);
    end
    held_after_reset(1'b0);
  endtask

  task automatic test_reset_mid_pulse();
    logic [3:0] got, exp;
    for (int i = 1; i <= 7; i++) begin
      tick(1'b1, 1'b0);
      exp = {(i == 7), 1'b0, 1'b0, 1'b1};
      got = {S, R, conflict, q_cmd};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL pulse_pre_reset cycle %0d: got {S,R,conflict,q_cmd}=%b required %b", i, got, exp);
      end
    end
    // Reset lands between clock edges; S and q_cmd must drop without waiting for an edge.
    #2;
    reset = 1'b1;
    #1;
    got = {S, R, conflict, q_cmd};
    tests_run++;
    if (got !== 4'b0000) begin
      tests_failed++;
      $display("FAIL pulse_cut_async: got {S,R,conflict,q_cmd}=%b required 0000", got);
    end
    @(posedge clk);
    held_after_reset(1'b0);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release(10);
    test_bounce();
    test_release(10);
    test_conflict();
    test_release(10);
    test_back_to_back();
    test_release(10);
    test_repress();
    test_release(10);
    test_reset_mid_debounce();
    test_release(10);
    test_reset_mid_pulse();
    test_release(10);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
